// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver / consumer side and the receive FIFO.
// Strobes: push and pop are single-cycle requests with no ready; full/empty tell the caller whether they will be taken.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  clr_ovf;

    modport master (
        output push, push_data, pop, clr_ovf,
        input  pop_data, empty, full, almost_full, count, overflow
    );

    modport slave (
        input  push, push_data, pop, clr_ovf,
        output pop_data, empty, full, almost_full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with fill level,
// almost-full warning and a sticky overflow flag for pushes that found no room.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  ovf_q;
    logic                  empty_w;
    logic                  full_w;
    logic                  do_pop;
    logic                  do_push;
    logic                  drop;
    logic [ADDR_WIDTH:0]   count_w;

    // Status comes only from registered pointers, so push/pop never reach the flags combinationally.
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count_w = wr_ptr - rd_ptr;

    // A pop on a full FIFO frees the slot the same-cycle push lands in; an empty FIFO never falls through.
    assign do_pop  = bus.pop && !empty_w;
    assign do_push = bus.push && (!full_w || do_pop);
    assign drop    = bus.push && !do_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    // Storage is deliberately left unreset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.push_data;
    end

    assign bus.pop_data    = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.count       = count_w;
    assign bus.almost_full = (count_w >= (ADDR_WIDTH+1)'(AF_LEVEL));
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus receiver-rate and random traffic,
// checked cycle by cycle against a queue model of a 16-entry FIFO.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   popped_total;

    logic [DW-1:0] exp_q[$];
    logic          exp_ovf;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every status output against the model's occupancy.
    task automatic check_status(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".count"}, 32'(bus.count), 32'(n));
        check({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AFL));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        if (n > 0) check({tag, ".pop_data"}, 32'(bus.pop_data), 32'(exp_q[0]));
    endtask

    // One clock of stimulus; called just after a rising edge, returns #1 after the next one.
    task automatic cycle(input logic push, input logic [DW-1:0] data, input logic pop,
                         input logic clr, input string tag);
        bit            pop_ok;
        bit            push_ok;
        logic [DW-1:0] head;
        bus.push      = push;
        bus.push_data = data;
        bus.pop       = pop;
        bus.clr_ovf   = clr;
        head          = bus.pop_data;
        pop_ok  = pop && (exp_q.size() > 0);
        push_ok = push && ((exp_q.size() < DEPTH) || pop_ok);
        @(posedge clk);
        if (pop_ok) begin
            check({tag, ".pop_byte"}, 32'(head), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            popped_total++;
        end
        if (push_ok) exp_q.push_back(data);
        if (push && !push_ok) exp_ovf = 1'b1;
        else if (clr)         exp_ovf = 1'b0;
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_ovf = 1'b0;
        check_status(tag);
    endtask

    task automatic apply_reset();
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        #1;
        check_status("reset_async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            pushed;
        logic [DW-1:0] next_byte;
        tests_run    = 0;
        tests_failed = 0;
        popped_total = 0;
        exp_ovf      = 1'b0;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.pop       = 1'b0;
        bus.clr_ovf   = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_status("reset");

        // single byte
        cycle(1'b1, 8'h41, 1'b0, 1'b0, "single_push");
        check("single_pop_data", 32'(bus.pop_data), 32'h41);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
        check("single_empty", 32'(bus.empty), 32'd1);

        // fill and flags
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        check("fill_full", 32'(bus.full), 32'd1);

        // overflow and sticky clear
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, "ovf_drop");
        check("ovf_set", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, "ovf_set_wins");
        check("ovf_set_wins_flag", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr2");

        // simultaneous push/pop when full
        cycle(1'b1, 8'h10, 1'b1, 1'b0, "pp_full");
        check("pp_full_count", 32'(bus.count), 32'd16);
        while (exp_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain_full");

        // simultaneous push/pop at count 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, "fill5");
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "pp_mid");
        check("pp_mid_count", 32'(bus.count), 32'd5);
        while (exp_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain_mid");

        // simultaneous push/pop when empty
        cycle(1'b1, 8'h77, 1'b1, 1'b0, "pp_empty");
        check("pp_empty_count", 32'(bus.count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "pp_empty_pop");

        // receiver-rate wrap-around: pushes spaced by idle gaps, pops interleaved
        popped_total = 0;
        pushed    = 0;
        next_byte = 8'h80;
        while (pushed < 40) begin
            cycle(1'b1, next_byte, ($urandom_range(0, 2) != 0), 1'b0, "wrap_push");
            next_byte++;
            pushed++;
            repeat ($urandom_range(1, 4)) cycle(1'b0, 8'h00, ($urandom_range(0, 3) == 0), 1'b0, "wrap_gap");
        end
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
        check("wrap_popped_total", 32'(popped_total), 32'd40);

        // random traffic, then reset in the middle of it
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) == 0), "rand");
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, "pre_reset");
        apply_reset();
        check_status("post_reset");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "pop_after_reset");
        check("pop_after_reset_empty", 32'(bus.empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule
